// File: rtl/song_pkg.sv
// Shared encodings for the song playback path.
// Word layout, op codes and scheduler states.
package song_pkg;

  localparam int PITCH_MSB = 31;
  localparam int PITCH_LSB = 26;
  localparam int DUR_MSB   = 25;
  localparam int DUR_LSB   = 14;
  localparam int GAP_MSB   = 13;
  localparam int GAP_LSB   = 2;
  localparam int OP_MSB    = 1;
  localparam int OP_LSB    = 0;

  typedef enum logic [1:0] {
    OP_NOTE = 2'b00,
    OP_REST = 2'b01,
    OP_END  = 2'b10,
    OP_LOOP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_GAP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [5:0]  pitch;
    logic [11:0] dur;
    logic [11:0] gap;
    op_e         op;
  } word_t;

  function automatic word_t unpack_word(input logic [31:0] d);
    word_t w;
    w.pitch = d[PITCH_MSB:PITCH_LSB];
    w.dur   = d[DUR_MSB:DUR_LSB];
    w.gap   = d[GAP_MSB:GAP_LSB];
    w.op    = op_e'(d[OP_MSB:OP_LSB]);
    return w;
  endfunction

endpackage

// File: rtl/note_scheduler_tick_countdown.sv
// 12-bit load/decrement-on-tick counter with zero flag.
// A pending tick at load time is absorbed into a nonzero load value.
module tick_countdown (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        pend,
  input  logic        dec,
  output logic        zero
);

  logic [11:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      if (pend && load_val != 12'd0)
        cnt <= load_val - 12'd1;
      else
        cnt <= load_val;
    end else if (dec && cnt != 12'd0) begin
      cnt <= cnt - 12'd1;
    end
  end

  assign zero = (cnt == 12'd0);

endmodule

// File: rtl/note_scheduler.sv
// Song sequencer: walks note words in song memory and
// issues timed note_trigger pulses to the action interpreter.
module note_scheduler
  import song_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [11:0] LEAD_TICKS = 12'd10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              note_trigger,
  output logic [17:0]       note_data,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] song_pos
);

  state_e state;
  word_t  w;
  logic   pend_q;
  logic   tick_ok;
  logic   fetching;
  logic   pend_eff;
  logic   last_addr;
  logic   lead_load;
  logic   gap_load;
  logic   lead_zero;
  logic   gap_zero;

  assign w         = unpack_word(rom_data);
  assign tick_ok   = tick & ~pause;
  assign fetching  = (state == S_FETCH) || (state == S_WAIT) ||
                     (state == S_DECODE);
  assign pend_eff  = pend_q | (tick_ok & fetching);
  assign last_addr = &rom_addr;
  assign playing   = (state != S_IDLE) && (state != S_DONE);

  assign lead_load = start && !stop;
  assign gap_load  = !stop && !start && (state == S_DECODE) &&
                     (w.op == OP_NOTE || w.op == OP_REST);

  tick_countdown u_lead (
    .clk      (clk),
    .reset    (reset),
    .load     (lead_load),
    .load_val (LEAD_TICKS),
    .pend     (1'b0),
    .dec      (tick_ok && state == S_LEAD),
    .zero     (lead_zero)
  );

  tick_countdown u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (w.gap),
    .pend     (pend_eff),
    .dec      (tick_ok && state == S_GAP),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rom_addr     <= '0;
      note_trigger <= 1'b0;
      note_data    <= '0;
      done         <= 1'b0;
      song_pos     <= '0;
      pend_q       <= 1'b0;
    end else begin
      note_trigger <= 1'b0;
      done         <= 1'b0;
      if (stop) begin
        state  <= S_IDLE;
        pend_q <= 1'b0;
      end else if (start) begin
        state    <= S_LEAD;
        rom_addr <= '0;
        pend_q   <= 1'b0;
      end else begin
        if (tick_ok && fetching)
          pend_q <= 1'b1;
        unique case (state)
          S_IDLE, S_DONE: ;
          S_LEAD:  if (lead_zero) state <= S_FETCH;
          S_FETCH: state <= S_WAIT;
          S_WAIT:  state <= S_DECODE;
          S_DECODE: begin
            unique case (w.op)
              OP_NOTE, OP_REST: begin
                if (w.op == OP_NOTE) begin
                  note_trigger <= 1'b1;
                  note_data    <= {w.pitch, w.dur};
                end
                song_pos <= rom_addr;
                // zero gap chains straight to the next fetch (chords)
                if (w.gap == 12'd0) begin
                  if (last_addr) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                  end else begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    state    <= S_FETCH;
                  end
                end else begin
                  state  <= S_GAP;
                  pend_q <= 1'b0;
                end
              end
              OP_LOOP: begin
                rom_addr <= '0;
                state    <= S_FETCH;
              end
              OP_END: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
          S_GAP: begin
            if (gap_zero) begin
              if (last_addr) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_FETCH;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a small BRAM model.
// Uses ADDR_W=2 so the address-wrap end is reachable.
module tb_note_scheduler;
  import song_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          start;
  logic          stop;
  logic          pause;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data = '0;
  logic          note_trigger;
  logic [17:0]   note_data;
  logic          playing;
  logic          done;
  logic [AW-1:0] song_pos;

  logic [31:0] mem [4];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int trig_cyc [64];
  int base;
  int dbase;
  int k;

  note_scheduler #(.ADDR_W(AW), .LEAD_TICKS(12'd2)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note_trigger (note_trigger),
    .note_data    (note_data),
    .playing      (playing),
    .done         (done),
    .song_pos     (song_pos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (note_trigger) begin
      if (trig_cnt < 64) trig_cyc[trig_cnt] <= cyc;
      trig_cnt <= trig_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] mk(input int p, input int d,
                                     input int g, input op_e op);
    logic [5:0]  pp;
    logic [11:0] dd;
    logic [11:0] gg;
    pp = p[5:0];
    dd = d[11:0];
    gg = g[11:0];
    return {pp, dd, gg, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    step(2);
    chk("rst_data", 32'(note_data), 32'h0);
    chk("rst_flags", {29'd0, note_trigger, playing, done}, 32'h0);
    chk("rst_addr", {28'd0, rom_addr, song_pos}, 32'h0);
    reset = 1'b1;
    step(1);

    // single note then END
    mem[0] = mk(5, 40, 3, OP_NOTE);
    mem[1] = mk(0, 0, 0, OP_END);
    base = trig_cnt;
    start_pulse();
    chk("t1_playing", 32'(playing), 32'h1);
    tick_pulse();
    step(4);
    chk("t1_early", trig_cnt, base);
    tick_pulse();
    step(6);
    chk("t1_trig", trig_cnt, base + 1);
    chk("t1_data", 32'(note_data), 32'h05028);
    chk("t1_pos", 32'(song_pos), 32'h0);
    tick_pulse();
    step(2);
    tick_pulse();
    step(2);
    chk("t1_nodone", done_cnt, 0);
    tick_pulse();
    step(6);
    chk("t1_done", done_cnt, 1);
    chk("t1_donepulse", 32'(done), 32'h0);
    chk("t1_stopped", 32'(playing), 32'h0);
    chk("t1_addr", 32'(rom_addr), 32'h1);

    // chord: three zero-gap notes from DONE restart
    mem[0] = mk(1, 10, 0, OP_NOTE);
    mem[1] = mk(2, 20, 0, OP_NOTE);
    mem[2] = mk(3, 30, 4, OP_NOTE);
    mem[3] = mk(0, 0, 0, OP_END);
    base = trig_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    step(14);
    chk("t2_count", trig_cnt, base + 3);
    chk("t2_gap01", trig_cyc[base + 1] - trig_cyc[base], 3);
    chk("t2_gap12", trig_cyc[base + 2] - trig_cyc[base + 1], 3);
    chk("t2_data", 32'(note_data), {14'd0, 6'd3, 12'd30});
    chk("t2_pos", 32'(song_pos), 32'h2);
    chk("t2_playing", 32'(playing), 32'h1);
    stop_pulse();
    chk("t2_stop", 32'(playing), 32'h0);
    chk("t2_keep", 32'(note_data), {14'd0, 6'd3, 12'd30});

    // pause mid-gap
    mem[0] = mk(7, 9, 5, OP_NOTE);
    mem[1] = mk(8, 1, 0, OP_NOTE);
    mem[2] = mk(0, 0, 0, OP_END);
    base  = trig_cnt;
    dbase = done_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    step(6);
    chk("t3_first", trig_cnt, base + 1);
    tick_pulse();
    step(1);
    tick_pulse();
    step(1);
    pause = 1'b1;
    repeat (10) begin
      tick_pulse();
      step(1);
    end
    step(3);
    chk("t3_frozen", trig_cnt, base + 1);
    chk("t3_nofetch", 32'(rom_addr), 32'h0);
    pause = 1'b0;
    tick_pulse();
    step(1);
    tick_pulse();
    step(6);
    chk("t3_remain", trig_cnt, base + 1);
    tick_pulse();
    step(6);
    chk("t3_second", trig_cnt, base + 2);
    chk("t3_data", 32'(note_data), {14'd0, 6'd8, 12'd1});
    chk("t3_pos", 32'(song_pos), 32'h1);
    step(4);
    chk("t3_done", done_cnt, dbase + 1);

    // tick during WAIT is held as pending
    mem[0] = mk(2, 2, 1, OP_NOTE);
    mem[1] = mk(3, 3, 2, OP_NOTE);
    mem[2] = mk(0, 0, 0, OP_END);
    base = trig_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    step(2);
    tick_pulse();
    step(8);
    chk("t4_count", trig_cnt, base + 2);
    chk("t4_spacing", trig_cyc[base + 1] - trig_cyc[base], 4);
    chk("t4_data", 32'(note_data), {14'd0, 6'd3, 12'd3});
    chk("t4_pos", 32'(song_pos), 32'h1);
    stop_pulse();

    // LOOP back to address 0
    mem[0] = mk(9, 5, 0, OP_NOTE);
    mem[1] = mk(10, 6, 0, OP_NOTE);
    mem[2] = mk(0, 0, 0, OP_LOOP);
    base = trig_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    k = 0;
    while (trig_cnt < base + 3 && k < 40) begin
      step(1);
      k++;
    end
    chk("t5_count", 32'(trig_cnt >= base + 3), 32'h1);
    chk("t5_data", 32'(note_data), {14'd0, 6'd9, 12'd5});
    chk("t5_pos", 32'(song_pos), 32'h0);
    chk("t5_sp01", trig_cyc[base + 1] - trig_cyc[base], 3);
    chk("t5_sp12", trig_cyc[base + 2] - trig_cyc[base + 1], 6);
    stop_pulse();

    // stop wins over start in GAP, then reset mid-LEAD
    mem[0] = mk(4, 4, 5, OP_NOTE);
    mem[1] = mk(0, 0, 0, OP_END);
    base = trig_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    step(6);
    chk("t6_trig", trig_cnt, base + 1);
    stop  = 1'b1;
    start = 1'b1;
    step(1);
    stop  = 1'b0;
    start = 1'b0;
    chk("t6_idle", 32'(playing), 32'h0);
    repeat (6) begin
      tick_pulse();
      step(1);
    end
    step(4);
    chk("t6_notrig", trig_cnt, base + 1);
    start_pulse();
    tick_pulse();
    chk("t6_lead", 32'(playing), 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_rst_data", 32'(note_data), 32'h0);
    chk("t6_rst_flags", {29'd0, note_trigger, playing, done}, 32'h0);
    chk("t6_rst_addr", {28'd0, rom_addr, song_pos}, 32'h0);
    step(1);
    reset = 1'b1;
    step(5);
    chk("t6_post", trig_cnt, base + 1);
    chk("t6_post_idle", 32'(playing), 32'h0);

    // last address advances into END, no wrap
    mem[0] = mk(11, 1, 0, OP_NOTE);
    mem[1] = mk(12, 2, 0, OP_NOTE);
    mem[2] = mk(13, 3, 0, OP_NOTE);
    mem[3] = mk(14, 4, 0, OP_NOTE);
    base  = trig_cnt;
    dbase = done_cnt;
    start_pulse();
    tick_pulse();
    tick_pulse();
    step(20);
    chk("t7_count", trig_cnt, base + 4);
    chk("t7_done", done_cnt, dbase + 1);
    chk("t7_stopped", 32'(playing), 32'h0);
    chk("t7_addr", 32'(rom_addr), 32'h3);
    chk("t7_pos", 32'(song_pos), 32'h3);
    chk("t7_data", 32'(note_data), {14'd0, 6'd14, 12'd4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
